// File: rtl/axis_pixel_unpacker_if.sv
// Stream bundle for the pixel unpacker: packed-word input side plus 8-bit pixel output side.
// "master" is the environment view, "slave" is the unpacker view.
interface axis_pixel_unpacker_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  s_axis_valid;
    logic [DATA_WIDTH-1:0] s_axis_data;
    logic                  s_axis_ready;
    logic                  m_axis_valid;
    logic [7:0]            m_axis_data;
    logic                  m_axis_last;
    logic                  m_axis_ready;

    modport master (
        output s_axis_valid, s_axis_data, m_axis_ready,
        input  s_axis_ready, m_axis_valid, m_axis_data, m_axis_last
    );

    modport slave (
        input  s_axis_valid, s_axis_data, m_axis_ready,
        output s_axis_ready, m_axis_valid, m_axis_data, m_axis_last
    );
endinterface

// File: rtl/axis_pixel_unpacker.sv
// Splits DATA_WIDTH-bit words into 8-bit pixels (LSB byte first), one per output handshake,
// flagging the last pixel of each FRAME_PIXELS frame and counting completed frames.
module axis_pixel_unpacker #(
    parameter int DATA_WIDTH   = 32,
    parameter int FRAME_PIXELS = 784,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 axi_clk,
    input  logic                 axi_reset,
    axis_pixel_unpacker_if.slave bus,
    output logic [CNT_WIDTH-1:0] frame_count
);
    localparam int BPW   = DATA_WIDTH / 8;
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int PIX_W = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(FRAME_PIXELS - 1);

    typedef enum logic {EMPTY, HOLD} state_t;

    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] word, word_n;
    logic [IDX_W-1:0]      byte_idx, byte_idx_n;
    logic [PIX_W-1:0]      pix_cnt, pix_cnt_n;
    logic [CNT_WIDTH-1:0]  frame_count_n;
    logic                  pix_hs, word_hs;

    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            state       <= EMPTY;
            word        <= '0;
            byte_idx    <= '0;
            pix_cnt     <= '0;
            frame_count <= '0;
        end else begin
            state       <= state_n;
            word        <= word_n;
            byte_idx    <= byte_idx_n;
            pix_cnt     <= pix_cnt_n;
            frame_count <= frame_count_n;
        end
    end

    // Reload is allowed on the same edge that consumes the final byte, so full-rate
    // streams never bubble between words.
    assign bus.s_axis_ready = (state == EMPTY) ||
                              (byte_idx == LAST_IDX && bus.m_axis_ready);
    assign bus.m_axis_valid = (state == HOLD);
    assign bus.m_axis_data  = word[{byte_idx, 3'b000} +: 8];
    assign bus.m_axis_last  = (state == HOLD) && (pix_cnt == LAST_PIX);

    assign pix_hs  = bus.m_axis_valid && bus.m_axis_ready;
    assign word_hs = bus.s_axis_valid && bus.s_axis_ready;

    always_comb begin
        state_n       = state;
        word_n        = word;
        byte_idx_n    = byte_idx;
        pix_cnt_n     = pix_cnt;
        frame_count_n = frame_count;
        if (pix_hs) begin
            byte_idx_n = byte_idx + IDX_W'(1);
            if (byte_idx == LAST_IDX)
                state_n = EMPTY;
            if (pix_cnt == LAST_PIX) begin
                pix_cnt_n     = '0;
                frame_count_n = frame_count + CNT_WIDTH'(1);
            end else begin
                pix_cnt_n = pix_cnt + PIX_W'(1);
            end
        end
        // A new word overrides the move to EMPTY taken above.
        if (word_hs) begin
            word_n     = bus.s_axis_data;
            byte_idx_n = '0;
            state_n    = HOLD;
        end
    end
endmodule

// File: tb/tb_axis_pixel_unpacker.sv
// Directed bench: cycle vector table for the basic handshakes plus streamed frames with a
// byte-queue scoreboard, mid-frame reset, and a small-frame build for counter wrap.
module tb_axis_pixel_unpacker;
    localparam int FP = 784;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [15:0] fc;
    logic [3:0]  fc2;

    always #5 clk = ~clk;

    axis_pixel_unpacker_if #(.DATA_WIDTH(32)) bus ();
    axis_pixel_unpacker_if #(.DATA_WIDTH(32)) bus2 ();

    axis_pixel_unpacker #(.DATA_WIDTH(32), .FRAME_PIXELS(FP), .CNT_WIDTH(16)) dut (
        .axi_clk(clk), .axi_reset(rst), .bus(bus), .frame_count(fc)
    );

    axis_pixel_unpacker #(.DATA_WIDTH(32), .FRAME_PIXELS(4), .CNT_WIDTH(4)) dut2 (
        .axi_clk(clk), .axi_reset(rst), .bus(bus2), .frame_count(fc2)
    );

    typedef struct {
        logic        sv;
        logic [31:0] sd;
        logic        mr;
        logic        e_sr;
        logic        e_mv;
        logic [7:0]  e_md;
        logic        e_ml;
    } vec_t;

    vec_t        vt[$];
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    int          pos = 0;
    int          exp_fc = 0;
    logic [7:0]  gen = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.s_axis_valid = 1'b0;
        bus.m_axis_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_m_valid", {31'd0, bus.m_axis_valid}, 0);
        chk("rst_m_data", {24'd0, bus.m_axis_data}, 0);
        chk("rst_m_last", {31'd0, bus.m_axis_last}, 0);
        chk("rst_s_ready", {31'd0, bus.s_axis_ready}, 1);
        chk("rst_frame_count", {16'd0, fc}, 0);
        exp_q.delete();
        pos = 0;
        exp_fc = 0;
    endtask

    // Streams npix pixels through the DUT; cycles = span from first to last pixel handshake.
    task automatic stream(input int npix, input bit gaps, input bit rnd, input int stall_at,
                          output int span);
        int got = 0, cyc = 0, pushed = 0, stalled = 0, first = -1;
        bit pv = 0, pr = 0, pl = 0;
        logic [7:0] pd = 0;
        span = 0;
        while (got < npix && cyc < 20000) begin
            @(negedge clk);
            bus.s_axis_valid = (pushed < npix) && (!gaps || $urandom_range(0, 2) != 0);
            bus.s_axis_data  = {gen + 8'd3, gen + 8'd2, gen + 8'd1, gen};
            if (stall_at >= 0 && got == stall_at && stalled < 5) begin
                bus.m_axis_ready = 1'b0;
                stalled++;
            end else begin
                bus.m_axis_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            #1;
            chk("frame_count", {16'd0, fc}, 32'(exp_fc) & 32'hFFFF);
            if (pv && !pr) begin
                chk("hold_valid", {31'd0, bus.m_axis_valid}, 1);
                chk("hold_data", {24'd0, bus.m_axis_data}, {24'd0, pd});
                chk("hold_last", {31'd0, bus.m_axis_last}, {31'd0, pl});
            end
            if (bus.s_axis_valid && bus.s_axis_ready) begin
                for (int b = 0; b < 4; b++) exp_q.push_back(gen + 8'(b));
                gen += 8'd4;
                pushed += 4;
            end
            if (bus.m_axis_valid && bus.m_axis_ready) begin
                if (exp_q.size() == 0) begin
                    chk("pixel_expected", 0, 1);
                end else begin
                    chk("pixel_data", {24'd0, bus.m_axis_data}, {24'd0, exp_q.pop_front()});
                    chk("pixel_last", {31'd0, bus.m_axis_last}, {31'd0, pos == FP - 1});
                end
                if (pos == FP - 1) begin
                    pos = 0;
                    exp_fc++;
                end else begin
                    pos++;
                end
                if (first < 0) first = cyc;
                span = cyc - first + 1;
                got++;
            end
            pv = bus.m_axis_valid; pr = bus.m_axis_ready;
            pd = bus.m_axis_data;  pl = bus.m_axis_last;
            cyc++;
        end
        chk("stream_done", got, npix);
        @(negedge clk);
        bus.s_axis_valid = 1'b0;
        #1;
        chk("frame_count_end", {16'd0, fc}, 32'(exp_fc) & 32'hFFFF);
    endtask

    initial begin
        int span;
        int lasts, acc;
        bus.s_axis_valid  = 1'b0;
        bus.s_axis_data   = '0;
        bus.m_axis_ready  = 1'b0;
        bus2.s_axis_valid = 1'b0;
        bus2.s_axis_data  = '0;
        bus2.m_axis_ready = 1'b0;

        //        sv  sd            mr  sr  mv  md     ml
        vt.push_back('{1, 32'h44332211, 1, 1, 0, 8'h00, 0});
        vt.push_back('{0, 32'h00000000, 1, 0, 1, 8'h11, 0});
        vt.push_back('{0, 32'h00000000, 1, 0, 1, 8'h22, 0});
        vt.push_back('{0, 32'h00000000, 1, 0, 1, 8'h33, 0});
        vt.push_back('{0, 32'h00000000, 1, 1, 1, 8'h44, 0});
        vt.push_back('{0, 32'h00000000, 1, 1, 0, 8'h00, 0});
        vt.push_back('{1, 32'hDDCCBBAA, 0, 1, 0, 8'h00, 0});
        vt.push_back('{1, 32'h12345678, 0, 0, 1, 8'hAA, 0});
        vt.push_back('{0, 32'h00000000, 1, 0, 1, 8'hAA, 0});
        vt.push_back('{0, 32'h00000000, 0, 0, 1, 8'hBB, 0});
        vt.push_back('{0, 32'h00000000, 1, 0, 1, 8'hBB, 0});
        vt.push_back('{0, 32'h00000000, 1, 0, 1, 8'hCC, 0});
        vt.push_back('{1, 32'h87654321, 0, 0, 1, 8'hDD, 0});
        vt.push_back('{1, 32'h87654321, 1, 1, 1, 8'hDD, 0});
        vt.push_back('{0, 32'h00000000, 1, 0, 1, 8'h21, 0});
        vt.push_back('{0, 32'h00000000, 1, 0, 1, 8'h43, 0});
        vt.push_back('{0, 32'h00000000, 1, 0, 1, 8'h65, 0});
        vt.push_back('{0, 32'h00000000, 1, 1, 1, 8'h87, 0});
        vt.push_back('{0, 32'h00000000, 1, 1, 0, 8'h00, 0});

        do_reset();
        foreach (vt[i]) begin
            @(negedge clk);
            bus.s_axis_valid = vt[i].sv;
            bus.s_axis_data  = vt[i].sd;
            bus.m_axis_ready = vt[i].mr;
            #1;
            chk($sformatf("vec%0d_s_ready", i), {31'd0, bus.s_axis_ready}, {31'd0, vt[i].e_sr});
            chk($sformatf("vec%0d_m_valid", i), {31'd0, bus.m_axis_valid}, {31'd0, vt[i].e_mv});
            chk($sformatf("vec%0d_m_last", i), {31'd0, bus.m_axis_last}, {31'd0, vt[i].e_ml});
            if (vt[i].e_mv)
                chk($sformatf("vec%0d_m_data", i), {24'd0, bus.m_axis_data}, {24'd0, vt[i].e_md});
        end

        // Partial frame with input gaps, then reset mid-frame.
        do_reset();
        stream(100, 1'b1, 1'b0, -1, span);
        do_reset();

        // Full frame at full rate: 784 handshakes in 784 consecutive cycles.
        stream(FP, 1'b0, 1'b0, -1, span);
        chk("full_rate_span", span, FP);
        chk("fc_after_frame1", {16'd0, fc}, 1);

        // Random output backpressure, input gaps and a 5-cycle stall mid-word.
        stream(FP, 1'b1, 1'b1, 301, span);
        chk("fc_after_frame2", {16'd0, fc}, 2);

        // 4-pixel frames on a 4-bit counter: 16 frames wrap frame_count to 0.
        lasts = 0;
        acc = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            bus2.s_axis_valid = (acc < 16);
            bus2.s_axis_data  = {4{8'(acc)}};
            bus2.m_axis_ready = 1'b1;
            #1;
            if (bus2.s_axis_valid && bus2.s_axis_ready) acc++;
            if (bus2.m_axis_valid && bus2.m_axis_ready && bus2.m_axis_last) begin
                chk("fc2_before_last", {28'd0, fc2}, 32'(lasts));
                lasts++;
            end
        end
        chk("fc2_last_count", lasts, 16);
        chk("fc2_wrapped", {28'd0, fc2}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
